// File: rtl/t3_match_decode_pkg.sv
// Shared Table-3 constants used by the T3 decode and the static match engine.
// Lane i address occupies [9i+8:9i]. Compare bit 2i is the port A hit and 2i+1 is the port B hit.
package t3_match_decode_pkg;

   localparam int unsigned T3_LANES = 16;
   localparam int unsigned T3_AW    = 9;
   localparam int unsigned T3_CW    = 2 * T3_LANES;

   // Index 0 is reserved, so it doubles as "no match".
   localparam logic [T3_AW-1:0] T3_NO_MATCH = '0;

endpackage

// File: rtl/t3_match_decode_path.sv
// One T3 decode path: per-lane A/B hit selection into a registered matched index.
module t3_match_decode_path
   import t3_match_decode_pkg::*;
#(
   parameter int unsigned LANES = T3_LANES,
   parameter int unsigned AW    = T3_AW,
   parameter int unsigned CW    = 2 * LANES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CW-1:0]       i_compare,
   input  logic [LANES*AW-1:0] i_addr_a,
   input  logic [LANES*AW-1:0] i_addr_b,
   output logic [LANES*AW-1:0] o_index
);

   logic [LANES*AW-1:0] w_next;
   logic [LANES*AW-1:0] r_index;

   // Port A takes priority. Addresses of lanes with no hit never reach the register.
   always_comb begin
      w_next = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         if (i_compare[2*i]) begin
            w_next[i*AW +: AW] = i_addr_a[i*AW +: AW];
         end else if (i_compare[2*i+1]) begin
            w_next[i*AW +: AW] = i_addr_b[i*AW +: AW];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_index <= '0;
      end else begin
         r_index <= w_next;
      end
   end

   assign o_index = r_index;

endmodule

// File: rtl/t3_match_decode.sv
// Decodes the case-sensitive and nocase T3 compare vectors into per-lane matched entry indices.
module t3_match_decode
   import t3_match_decode_pkg::*;
#(
   parameter int unsigned LANES = T3_LANES,
   parameter int unsigned AW    = T3_AW,
   parameter int unsigned CW    = T3_CW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CW-1:0]       iCompareVector,
   input  logic [CW-1:0]       iCompareVector_nocase,
   input  logic [LANES*AW-1:0] iAddr_portA,
   input  logic [LANES*AW-1:0] iAddr_portB,
   input  logic [LANES*AW-1:0] iAddr_portA_nocase,
   input  logic [LANES*AW-1:0] iAddr_portB_nocase,
   output logic [LANES*AW-1:0] oIndex,
   output logic [LANES*AW-1:0] oIndex_nocase
);

   t3_match_decode_path #(
      .LANES (LANES),
      .AW    (AW),
      .CW    (CW)
   ) u_path_case (
      .clk       (clk),
      .rst       (rst),
      .i_compare (iCompareVector),
      .i_addr_a  (iAddr_portA),
      .i_addr_b  (iAddr_portB),
      .o_index   (oIndex)
   );

   t3_match_decode_path #(
      .LANES (LANES),
      .AW    (AW),
      .CW    (CW)
   ) u_path_nocase (
      .clk       (clk),
      .rst       (rst),
      .i_compare (iCompareVector_nocase),
      .i_addr_a  (iAddr_portA_nocase),
      .i_addr_b  (iAddr_portB_nocase),
      .o_index   (oIndex_nocase)
   );

endmodule

// File: tb/tb_t3_match_decode.sv
// Directed self-checking bench for t3_match_decode.
module tb_t3_match_decode;

   logic         clk;
   logic         rst;
   logic [31:0]  cmp;
   logic [31:0]  cmp_nc;
   logic [143:0] addr_a;
   logic [143:0] addr_b;
   logic [143:0] addr_a_nc;
   logic [143:0] addr_b_nc;
   logic [143:0] o_idx;
   logic [143:0] o_idx_nc;
   logic [143:0] exp;
   logic [143:0] exp_nc;

   int n_vec = 0;
   int n_err = 0;

   t3_match_decode dut (
      .clk                   (clk),
      .rst                   (rst),
      .iCompareVector        (cmp),
      .iCompareVector_nocase (cmp_nc),
      .iAddr_portA           (addr_a),
      .iAddr_portB           (addr_b),
      .iAddr_portA_nocase    (addr_a_nc),
      .iAddr_portB_nocase    (addr_b_nc),
      .oIndex                (o_idx),
      .oIndex_nocase         (o_idx_nc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [143:0] rand144();
      logic [159:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return r[143:0];
   endfunction

   // Advance one rising edge, then sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      cmp       = '0;
      cmp_nc    = '0;
      addr_a    = rand144();
      addr_b    = rand144();
      addr_a_nc = rand144();
      addr_b_nc = rand144();
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      cmp       = $urandom();
      cmp_nc    = $urandom();
      addr_a    = rand144();
      addr_b    = rand144();
      addr_a_nc = rand144();
      addr_b_nc = rand144();
      tick();
      tick();
      n_vec++;
      if (o_idx !== 144'h0) begin
         n_err++;
         $display("FAIL reset_case got %h want 0", o_idx);
      end
      n_vec++;
      if (o_idx_nc !== 144'h0) begin
         n_err++;
         $display("FAIL reset_nocase got %h want 0", o_idx_nc);
      end
      clear_inputs();
      #2 rst = 1'b1;
      tick();
      n_vec++;
      if (o_idx !== 144'h0 || o_idx_nc !== 144'h0) begin
         n_err++;
         $display("FAIL reset_release got %h / %h want 0 / 0", o_idx, o_idx_nc);
      end
   endtask

   task automatic test_single_a();
      clear_inputs();
      cmp           = 32'h1;
      addr_a[8:0]   = 9'd37;
      tick();
      exp           = '0;
      exp[8:0]      = 9'd37;
      n_vec++;
      if (o_idx !== exp) begin
         n_err++;
         $display("FAIL single_a got %h want %h", o_idx, exp);
      end
      n_vec++;
      if (o_idx_nc !== 144'h0) begin
         n_err++;
         $display("FAIL single_a_nocase got %h want 0", o_idx_nc);
      end
   endtask

   task automatic test_single_b();
      clear_inputs();
      cmp               = 32'h8000_0000;
      addr_b[143:135]   = 9'd511;
      tick();
      exp               = '0;
      exp[143:135]      = 9'd511;
      n_vec++;
      if (o_idx !== exp) begin
         n_err++;
         $display("FAIL single_b got %h want %h", o_idx, exp);
      end
   endtask

   task automatic test_priority();
      clear_inputs();
      cmp            = 32'h0000_00C0;
      addr_a[35:27]  = 9'd100;
      addr_b[35:27]  = 9'd200;
      tick();
      exp            = '0;
      exp[35:27]     = 9'd100;
      n_vec++;
      if (o_idx !== exp) begin
         n_err++;
         $display("FAIL priority_a_over_b got %h want %h", o_idx, exp);
      end
   endtask

   task automatic test_path_indep();
      clear_inputs();
      cmp_nc           = 32'h0000_0004;
      addr_a_nc[17:9]  = 9'd5;
      tick();
      exp_nc           = '0;
      exp_nc[17:9]     = 9'd5;
      n_vec++;
      if (o_idx_nc !== exp_nc) begin
         n_err++;
         $display("FAIL path_indep_nocase got %h want %h", o_idx_nc, exp_nc);
      end
      n_vec++;
      if (o_idx !== 144'h0) begin
         n_err++;
         $display("FAIL path_indep_case got %h want 0", o_idx);
      end
   endtask

   task automatic test_all_lanes();
      // Every lane hits A: lane i carries i+1 on A, 511 on B.
      clear_inputs();
      exp = '0;
      for (int i = 0; i < 16; i++) begin
         addr_a[i*9 +: 9] = 9'(i + 1);
         addr_b[i*9 +: 9] = 9'd511;
         exp[i*9 +: 9]    = 9'(i + 1);
      end
      cmp = 32'h5555_5555;
      tick();
      n_vec++;
      if (o_idx !== exp) begin
         n_err++;
         $display("FAIL all_lanes_a got %h want %h", o_idx, exp);
      end
      // Every lane hits B only.
      cmp = 32'hAAAA_AAAA;
      exp = '0;
      for (int i = 0; i < 16; i++) exp[i*9 +: 9] = 9'd511;
      tick();
      n_vec++;
      if (o_idx !== exp) begin
         n_err++;
         $display("FAIL all_lanes_b got %h want %h", o_idx, exp);
      end
      // Mixed: lane0 B, lane2 A, lane5 both (A wins); nocase lane7 B.
      clear_inputs();
      cmp               = 32'h0000_0C12;
      addr_a[8:0]       = 9'd11;
      addr_b[8:0]       = 9'd22;
      addr_a[26:18]     = 9'd33;
      addr_a[53:45]     = 9'd44;
      addr_b[53:45]     = 9'd55;
      cmp_nc            = 32'h0000_8000;
      addr_b_nc[71:63]  = 9'd300;
      exp               = '0;
      exp[8:0]          = 9'd22;
      exp[26:18]        = 9'd33;
      exp[53:45]        = 9'd44;
      exp_nc            = '0;
      exp_nc[71:63]     = 9'd300;
      tick();
      n_vec++;
      if (o_idx !== exp) begin
         n_err++;
         $display("FAIL mixed_case got %h want %h", o_idx, exp);
      end
      n_vec++;
      if (o_idx_nc !== exp_nc) begin
         n_err++;
         $display("FAIL mixed_nocase got %h want %h", o_idx_nc, exp_nc);
      end
   endtask

   task automatic test_latency_clear();
      clear_inputs();
      tick();
      cmp               = 32'h0000_0100;
      addr_a[44:36]     = 9'd77;
      cmp_nc            = 32'h0000_0001;
      addr_a_nc[8:0]    = 9'd88;
      #2;
      n_vec++;
      if (o_idx !== 144'h0) begin
         n_err++;
         $display("FAIL no_comb_path got %h want 0", o_idx);
      end
      tick();
      exp               = '0;
      exp[44:36]        = 9'd77;
      exp_nc            = '0;
      exp_nc[8:0]       = 9'd88;
      n_vec++;
      if (o_idx !== exp || o_idx_nc !== exp_nc) begin
         n_err++;
         $display("FAIL latency_n1 got %h / %h want %h / %h", o_idx, o_idx_nc, exp, exp_nc);
      end
      clear_inputs();
      tick();
      n_vec++;
      if (o_idx !== 144'h0 || o_idx_nc !== 144'h0) begin
         n_err++;
         $display("FAIL clear_n2 got %h / %h want 0 / 0", o_idx, o_idx_nc);
      end
      // Load again, then assert reset between edges.
      cmp            = 32'h0000_0100;
      addr_a[44:36]  = 9'd77;
      cmp_nc         = 32'h0000_0001;
      addr_a_nc[8:0] = 9'd88;
      tick();
      n_vec++;
      if (o_idx !== exp || o_idx_nc !== exp_nc) begin
         n_err++;
         $display("FAIL reload got %h / %h want %h / %h", o_idx, o_idx_nc, exp, exp_nc);
      end
      #2 rst = 1'b0;
      #1;
      n_vec++;
      if (o_idx !== 144'h0 || o_idx_nc !== 144'h0) begin
         n_err++;
         $display("FAIL async_reset got %h / %h want 0 / 0", o_idx, o_idx_nc);
      end
      tick();
      n_vec++;
      if (o_idx !== 144'h0 || o_idx_nc !== 144'h0) begin
         n_err++;
         $display("FAIL reset_hold got %h / %h want 0 / 0", o_idx, o_idx_nc);
      end
      #2 rst = 1'b1;
      tick();
      n_vec++;
      if (o_idx !== exp || o_idx_nc !== exp_nc) begin
         n_err++;
         $display("FAIL after_reset got %h / %h want %h / %h", o_idx, o_idx_nc, exp, exp_nc);
      end
   endtask

   initial begin
      test_reset();
      test_single_a();
      test_single_b();
      test_priority();
      test_path_indep();
      test_all_lanes();
      test_latency_clear();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/t3_match_decode.md
Name: t3_match_decode

Overview:
- Decodes the Table‑3 (T3) compare vectors produced by the static match engine into per‑lane matched T3 entry indices.
- There are two independent, identical paths: case‑sensitive and case‑insensitive (nocase).
- Each path has 16 lanes. Each lane has one 9‑bit address from BRAM port A and one from port B, plus two compare bits.
- The block sits directly after match_static_engine and feeds pattern reporting and debug logging.

Parameters:
- LANES, 16, number of T3 lookup lanes per path.
- AW, 9, T3 address width per lane.
- CW, 32, compare vector width (2*LANES).

Ports:
- clk  in  1  system clock, rising‑edge.
- rst  in  1  asynchronous, active‑low reset (0 = reset asserted).
- iCompareVector  in  32  case‑sensitive compare hits. Bit 2i = lane i port A hit; bit 2i+1 = lane i port B hit.
- iCompareVector_nocase  in  32  nocase compare hits, same bit mapping.
- iAddr_portA  in  144  case‑sensitive port A addresses. Lane i occupies bits [9i+8:9i].
- iAddr_portB  in  144  case‑sensitive port B addresses, same packing.
- iAddr_portA_nocase  in  144  nocase port A addresses, same packing.
- iAddr_portB_nocase  in  144  nocase port B addresses, same packing.
- oIndex  out  144  case‑sensitive decoded index. Lane i occupies bits [9i+8:9i].
- oIndex_nocase  out  144  nocase decoded index, same packing.

Behaviour:
- Reset: while rst=0, oIndex and oIndex_nocase are 0 asynchronously, and they stay 0 until the first rising clk after rst goes to 1.
- Per lane i, per path, the next value is selected as follows:
  - compare bit 2i = 1 → next = portA lane i address.
  - else compare bit 2i+1 = 1 → next = portB lane i address.
  - else next = 0.
- Simultaneous A and B hits in the same lane: port A wins.
- Index value 0 means "no match". T3 entry 0 is reserved and never holds a valid pattern.
- Latency: exactly one clk cycle. Inputs sampled at rising edge N appear on the outputs after edge N. Outputs are registered with no combinational path from input to output.
- Lanes and paths are fully independent. A hit in one lane or path never affects another.
- No enable or handshake. The block updates every cycle, so a zero compare vector clears that path to all zeros on the next edge.
- Addresses pass through unmodified, full 9‑bit width. Address bits of lanes whose compare bits are 0 are ignored, including X values.
- Reset asserted mid‑operation clears both outputs immediately, independent of clk.

Decomposition:
- Shared package holds T3_LANES=16, T3_AW=9, T3_CW=32, plus the lane slice convention (lane i at [9i+8:9i]; compare bits 2i/2i+1). match_static_engine uses the same package.
- One sub‑module: t3_match_decode_path. It implements a single 16‑lane path (compare vector, port A, port B → registered index) and is instantiated twice, once for case and once for nocase.

Test Plan:
1. Reset: hold rst=0 with random inputs → oIndex=0 and oIndex_nocase=0. Release rst and apply compare=0 → outputs remain 0.
2. Single A hit: iCompareVector=32'h1, lane0 portA=9'd37 → after one edge, oIndex[8:0]=37, all other lanes 0, oIndex_nocase=0.
3. Single B hit: iCompareVector=32'h8000_0000, lane15 portB=9'd511 → oIndex[143:135]=511, all other lanes 0.
4. A/B priority: lane3 compare bits 2'b11, portA=9'd100, portB=9'd200 → oIndex[35:27]=100.
5. Path independence: nocase vector 32'h0000_0004 (lane1 A), portA_nocase lane1=9'd5; case vector=0 → oIndex_nocase[17:9]=5, oIndex=0.
6. Latency/clear: hits on cycle N only → outputs nonzero only on cycle N+1 and return to 0 on N+2. Assert rst mid‑cycle → outputs 0 immediately.
